// File: rtl/pit_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pit_ctrl_pkg
// Brief    : Shared constants for the programmable interval timer sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pit_ctrl_pkg;

    localparam int c_WIDTH_DEFAULT = 16;

    localparam int         c_ST_W    = 2;
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pit_ctrl_upcnt_n.sv
`default_nettype none
// ============================================================================
// Module   : upcnt_n
// Brief    : WIDTH-bit up counter built from 1-bit count/carry slices, with
//            enable, synchronous clear (dominant) and carry-out.
// Revision : 1.0 - initial release
// ============================================================================
module upcnt_n
    import pit_ctrl_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             co
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] r_q;

    // Each slice toggles when every lower slice is 1 and the count is enabled.
    assign w_carry[0] = en;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
            assign w_carry[gi+1] = w_carry[gi] & r_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else begin
            r_q <= r_q ^ w_carry[WIDTH-1:0];
        end
    end

    assign q  = r_q;
    assign co = w_carry[WIDTH];

endmodule
`default_nettype wire

// File: rtl/pit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pit_ctrl
// Brief    : Programmable interval timer sequencer: prescaler + divider chain,
//            start/stop/reload sequencing and one-cycle expiry interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module pit_ctrl
    import pit_ctrl_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             ld_pre,
    input  logic             ld_div,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    output logic             tick,
    output logic             irq,
    output logic             running,
    output logic [WIDTH-1:0] cnt_q
);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_nxt;
    logic              r_mode;
    logic              w_mode_nxt;
    logic [WIDTH-1:0]  r_pre_reg;
    logic [WIDTH-1:0]  r_div_reg;
    logic [WIDTH-1:0]  w_pre_cnt;
    logic [WIDTH-1:0]  w_div_cnt;
    logic              r_irq;

    logic w_run;
    logic w_ld;
    logic w_pre_hit;
    logic w_div_hit;
    logic w_expiry;
    logic w_count;
    logic w_clr_all;
    logic w_pre_co_unused;
    logic w_div_co_unused;

    assign w_run     = (r_state == c_ST_RUN);
    assign w_ld      = ld_pre | ld_div;
    assign w_pre_hit = (w_pre_cnt == r_pre_reg);
    assign w_div_hit = (w_div_cnt == r_div_reg);
    assign tick      = w_run & w_pre_hit;
    // A reload restarts the period, so an expiry coinciding with it is dropped.
    assign w_expiry  = tick & w_div_hit & ~w_ld;

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_count     = 1'b0;
        w_clr_all   = 1'b0;
        if (stop) begin
            w_state_nxt = c_ST_IDLE;
        end else if (start) begin
            w_state_nxt = c_ST_RUN;
            w_mode_nxt  = oneshot;
            w_clr_all   = 1'b1;
        end else if (w_run) begin
            if (w_ld) begin
                w_clr_all = 1'b1;
            end else if (w_expiry && r_mode) begin
                w_state_nxt = c_ST_DONE;
                w_clr_all   = 1'b1;
            end else begin
                w_count = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_mode    <= 1'b0;
            r_pre_reg <= '0;
            r_div_reg <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_irq   <= w_expiry;
            if (ld_pre) begin
                r_pre_reg <= din;
            end
            if (ld_div) begin
                r_div_reg <= din;
            end
        end
    end

    // Equality with the period register clears each stage instead of wrapping.
    upcnt_n #(
        .WIDTH (WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (w_count),
        .clr   (w_clr_all | (w_count & w_pre_hit)),
        .q     (w_pre_cnt),
        .co    (w_pre_co_unused)
    );

    upcnt_n #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk   (clk),
        .reset (reset),
        .en    (w_count & w_pre_hit),
        .clr   (w_clr_all | (w_count & w_pre_hit & w_div_hit)),
        .q     (w_div_cnt),
        .co    (w_div_co_unused)
    );

    assign irq     = r_irq;
    assign running = w_run;
    assign cnt_q   = w_div_cnt;

endmodule
`default_nettype wire
